// File: rtl/phasor_gen_if.sv
// Phasor generator stream interface.
// Groups the sequence-request signals and the phasor output stream.
// Parameters:
//   AW : angle index width
//   CW : phasor component width (signed)
// Signals:
//   start/start_angle/step/count : sequence request from the controller
//   busy                         : generator is running a sequence
//   c_re/c_im/c_angle/c_last     : phasor payload
//   c_valid/c_ready              : output stream handshake
// Modports:
//   master : controller/consumer side (drives requests and c_ready)
//   slave  : generator side
interface phasor_gen_if #(
  parameter int AW = 12,
  parameter int CW = 16
) ();
  logic                 start;
  logic [AW-1:0]        start_angle;
  logic [AW-1:0]        step;
  logic [AW:0]          count;
  logic                 busy;
  logic signed [CW-1:0] c_re;
  logic signed [CW-1:0] c_im;
  logic [AW-1:0]        c_angle;
  logic                 c_last;
  logic                 c_valid;
  logic                 c_ready;

  modport master (
    output start, start_angle, step, count, c_ready,
    input  busy, c_re, c_im, c_angle, c_last, c_valid
  );

  modport slave (
    input  start, start_angle, step, count, c_ready,
    output busy, c_re, c_im, c_angle, c_last, c_valid
  );
endinterface

// File: rtl/phasor_gen.sv
// Unit-magnitude phasor generator for the SDFT rotators.
// For each angle index a it emits exp(+/-j*2*pi*a/N) in CW-bit signed fixed
// point (full scale 2**(CW-1)-1 == 1.0). Only a quarter-wave cosine table is
// stored; the other quadrants come from sign/swap symmetry.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : phasor_gen_if.slave (start/start_angle/step/count request,
//           busy, c_re/c_im/c_angle/c_last stream with c_valid/c_ready)
// Parameters:
//   N       : points per full turn (power of two, >= 16)
//   CW      : component width
//   INVERSE : 1 emits the conjugate phasor (c_im = -sin)
module phasor_gen #(
  parameter int N       = 4096,
  parameter int CW      = 16,
  parameter int INVERSE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  phasor_gen_if.slave  bus
);

  localparam int AW  = $clog2(N);
  localparam int QTR = N / 4;
  localparam int FS  = 2**(CW-1) - 1;

  typedef enum logic {IDLE, RUN} state_t;

  // Quarter-wave cosine entry; all entries are non-negative so a simple
  // +0.5 truncation rounds to nearest.
  function automatic int cosEntry(input int i);
    real v;
    v = $cos(2.0 * 3.14159265358979323846 * real'(i) / real'(N)) * real'(FS);
    return $rtoi(v + 0.5);
  endfunction

  // Quarter-wave table T[0..N/4], fixed at elaboration.
  logic [CW-1:0] romT [0:QTR];

  genvar g;
  generate
    for (g = 0; g <= QTR; g++) begin : gRom
      localparam logic [CW-1:0] TV = CW'(cosEntry(g));
      assign romT[g] = TV;
    end
  endgenerate

  state_t        state_q;
  logic          busy_q;
  logic [AW-1:0] angle_q;
  logic [AW-1:0] step_q;
  logic [AW:0]   remain_q;

  logic          s1Valid_q;
  logic [1:0]    s1Quad_q;
  logic [AW-2:0] s1AddrA_q;
  logic [AW-2:0] s1AddrB_q;
  logic [AW-1:0] s1Angle_q;
  logic          s1Last_q;

  logic          s2Valid_q;
  logic [1:0]    s2Quad_q;
  logic [CW-1:0] s2A_q;
  logic [CW-1:0] s2B_q;
  logic [AW-1:0] s2Angle_q;
  logic          s2Last_q;

  logic                 advance;
  logic                 issue;
  logic                 lastHs;
  logic signed [CW-1:0] re_d;
  logic signed [CW-1:0] sin_d;
  logic signed [CW-1:0] im_d;

  // A stalled output register freezes the whole pipe and the issue counter.
  assign advance = !(bus.c_valid && !bus.c_ready);
  assign issue   = (state_q == RUN) && (remain_q != '0) && advance;
  assign lastHs  = bus.c_valid && bus.c_ready && bus.c_last;
  assign bus.busy = busy_q;

  // Sequence control: latches the request, walks the angle counter and
  // returns to IDLE only once the final phasor has been accepted downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      angle_q  <= '0;
      step_q   <= '0;
      remain_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && (bus.count != '0)) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            angle_q  <= bus.start_angle;
            step_q   <= bus.step;
            remain_q <= bus.count;
          end
        end
        RUN: begin
          if (issue) begin
            angle_q  <= angle_q + step_q;
            remain_q <= remain_q - (AW+1)'(1);
          end
          if (lastHs) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output sign/swap: the quadrant selects which table value is the cosine
  // and which is the sine, and their signs.
  always_comb begin
    re_d  = '0;
    sin_d = '0;
    case (s2Quad_q)
      2'd0: begin re_d =  $signed(s2A_q); sin_d =  $signed(s2B_q); end
      2'd1: begin re_d = -$signed(s2B_q); sin_d =  $signed(s2A_q); end
      2'd2: begin re_d = -$signed(s2A_q); sin_d = -$signed(s2B_q); end
      default: begin re_d = $signed(s2B_q); sin_d = -$signed(s2A_q); end
    endcase
    im_d = (INVERSE != 0) ? -sin_d : sin_d;
  end

  // Three-stage datapath: address split, table read, sign/swap register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q   <= 1'b0;
      s1Quad_q    <= '0;
      s1AddrA_q   <= '0;
      s1AddrB_q   <= '0;
      s1Angle_q   <= '0;
      s1Last_q    <= 1'b0;
      s2Valid_q   <= 1'b0;
      s2Quad_q    <= '0;
      s2A_q       <= '0;
      s2B_q       <= '0;
      s2Angle_q   <= '0;
      s2Last_q    <= 1'b0;
      bus.c_valid <= 1'b0;
      bus.c_re    <= '0;
      bus.c_im    <= '0;
      bus.c_angle <= '0;
      bus.c_last  <= 1'b0;
    end else if (advance) begin
      s1Valid_q <= issue;
      if (issue) begin
        s1Quad_q  <= angle_q[AW-1:AW-2];
        s1AddrA_q <= {1'b0, angle_q[AW-3:0]};
        s1AddrB_q <= (AW-1)'(QTR) - {1'b0, angle_q[AW-3:0]};
        s1Angle_q <= angle_q;
        s1Last_q  <= (remain_q == (AW+1)'(1));
      end
      s2Valid_q   <= s1Valid_q;
      s2Quad_q    <= s1Quad_q;
      s2A_q       <= romT[s1AddrA_q];
      s2B_q       <= romT[s1AddrB_q];
      s2Angle_q   <= s1Angle_q;
      s2Last_q    <= s1Last_q;
      bus.c_valid <= s2Valid_q;
      bus.c_re    <= re_d;
      bus.c_im    <= im_d;
      bus.c_angle <= s2Angle_q;
      bus.c_last  <= s2Valid_q && s2Last_q;
    end
  end

endmodule

// File: tb/tb_phasor_gen.sv
// Testbench for phasor_gen: two instances (INVERSE=0 and INVERSE=1) share
// one stimulus stream; expected phasors come from a cos/sin model pushed into
// per-instance queues at launch and popped on each output handshake.
module tb_phasor_gen;

  localparam int N  = 4096;
  localparam int AW = 12;
  localparam int CW = 16;
  localparam real K = 32767.0;

  typedef struct {
    int angle;
    int re;
    int im;
    bit last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] startAngle;
  logic [AW-1:0] stepIn;
  logic [AW:0]   countIn;
  logic          cReady;

  int testsRun = 0;
  int testsFailed = 0;
  int hs0 = 0;
  int hs1 = 0;
  int last0 = 0;

  exp_t expQ0[$];
  exp_t expQ1[$];
  exp_t e0, e1;
  int   dRe, dIm;

  bit                   prevStall = 1'b0;
  logic signed [CW-1:0] prevRe, prevIm;
  logic [AW-1:0]        prevAngle;
  logic                 prevLast;

  phasor_gen_if #(.AW(AW), .CW(CW)) bus0 ();
  phasor_gen_if #(.AW(AW), .CW(CW)) bus1 ();

  assign bus0.start       = start;
  assign bus0.start_angle = startAngle;
  assign bus0.step        = stepIn;
  assign bus0.count       = countIn;
  assign bus0.c_ready     = cReady;
  assign bus1.start       = start;
  assign bus1.start_angle = startAngle;
  assign bus1.step        = stepIn;
  assign bus1.count       = countIn;
  assign bus1.c_ready     = cReady;

  phasor_gen #(.N(N), .CW(CW), .INVERSE(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  phasor_gen #(.N(N), .CW(CW), .INVERSE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Absolute bound on simulated time.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // Scoreboard side: pop and compare on every handshake, and check that a
  // stalled output holds its payload until accepted.
  always @(negedge clk) begin
    if (rst_n && bus0.c_valid && cReady) begin
      hs0++;
      if (bus0.c_last) last0++;
      testsRun++;
      if (expQ0.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL dut0_unexpected: got angle %0d, expected no output", bus0.c_angle);
      end else begin
        e0  = expQ0.pop_front();
        dRe = int'(bus0.c_re) - e0.re;
        dIm = int'(bus0.c_im) - e0.im;
        if (int'(bus0.c_angle) !== e0.angle || bus0.c_last !== e0.last ||
            dRe > 1 || dRe < -1 || dIm > 1 || dIm < -1) begin
          testsFailed++;
          $display("[TB] FAIL dut0_phasor: got a=%0d re=%0d im=%0d last=%0d, expected a=%0d re=%0d im=%0d last=%0d",
                   bus0.c_angle, bus0.c_re, bus0.c_im, bus0.c_last, e0.angle, e0.re, e0.im, e0.last);
        end
      end
    end
    if (rst_n && bus1.c_valid && cReady) begin
      hs1++;
      testsRun++;
      if (expQ1.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL dut1_unexpected: got angle %0d, expected no output", bus1.c_angle);
      end else begin
        e1  = expQ1.pop_front();
        dRe = int'(bus1.c_re) - e1.re;
        dIm = int'(bus1.c_im) - e1.im;
        if (int'(bus1.c_angle) !== e1.angle || bus1.c_last !== e1.last ||
            dRe > 1 || dRe < -1 || dIm > 1 || dIm < -1) begin
          testsFailed++;
          $display("[TB] FAIL dut1_phasor: got a=%0d re=%0d im=%0d last=%0d, expected a=%0d re=%0d im=%0d last=%0d",
                   bus1.c_angle, bus1.c_re, bus1.c_im, bus1.c_last, e1.angle, e1.re, e1.im, e1.last);
        end
      end
    end
    if (prevStall) begin
      testsRun++;
      if (bus0.c_valid !== 1'b1 || bus0.c_re !== prevRe || bus0.c_im !== prevIm ||
          bus0.c_angle !== prevAngle || bus0.c_last !== prevLast) begin
        testsFailed++;
        $display("[TB] FAIL stall_hold: got v=%0d a=%0d re=%0d im=%0d, expected v=1 a=%0d re=%0d im=%0d",
                 bus0.c_valid, bus0.c_angle, bus0.c_re, bus0.c_im, prevAngle, prevRe, prevIm);
      end
    end
    prevStall = rst_n && bus0.c_valid && !cReady;
    prevRe    = bus0.c_re;
    prevIm    = bus0.c_im;
    prevAngle = bus0.c_angle;
    prevLast  = bus0.c_last;
  end

  // Pulses start for one cycle and, when the request should run, pushes the
  // model's phasors for both instances.
  task automatic applyStimulus(input int sa, input int st, input int cnt, input bit push);
    int   a;
    real  th;
    int   re, s;
    if (push) begin
      for (int i = 0; i < cnt; i++) begin
        a  = (sa + i * st) % N;
        th = 2.0 * 3.14159265358979323846 * real'(a) / real'(N);
        re = rnd($cos(th) * K);
        s  = rnd($sin(th) * K);
        expQ0.push_back('{a, re, s, (i == cnt - 1)});
        expQ1.push_back('{a, re, -s, (i == cnt - 1)});
      end
    end
    @(posedge clk); #1;
    start      = 1'b1;
    startAngle = sa[AW-1:0];
    stepIn     = st[AW-1:0];
    countIn    = cnt[AW:0];
    @(posedge clk); #1;
    start      = 1'b0;
    startAngle = AW'($urandom);
    stepIn     = AW'($urandom);
    countIn    = (AW+1)'($urandom);
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!bus0.busy && !bus1.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cReady = 1'b1;
    startAngle = '0; stepIn = '0; countIn = '0;
    #23;
    testsRun++;
    if (bus0.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0d, expected 0", bus0.busy); end
    testsRun++;
    if (bus0.c_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %0d, expected 0", bus0.c_valid); end
    testsRun++;
    if (bus0.c_last !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_last: got %0d, expected 0", bus0.c_last); end
    testsRun++;
    if (bus0.c_re !== '0 || bus0.c_im !== '0 || bus0.c_angle !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got re=%0d im=%0d a=%0d, expected 0 0 0", bus0.c_re, bus0.c_im, bus0.c_angle);
    end
    testsRun++;
    if (bus1.busy !== 1'b0 || bus1.c_valid !== 1'b0 || bus1.c_re !== '0 || bus1.c_im !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_dut1: got busy=%0d v=%0d re=%0d im=%0d, expected all 0",
               bus1.busy, bus1.c_valid, bus1.c_re, bus1.c_im);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int h0, h1, l0, cyc;
    bit ok;
    h0 = hs0; h1 = hs1; l0 = last0;
    applyStimulus(0, 1024, 4, 1'b1);
    testsRun++;
    if (bus0.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_busy_rise: got %0d, expected 1", bus0.busy); end
    cyc = 0;
    while (!bus0.c_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    testsRun++;
    if (cyc != 3) begin testsFailed++; $display("[TB] FAIL basic_latency: got %0d cycles, expected 3", cyc); end
    waitDone(50, ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL basic_done: got timeout, expected busy to fall"); end
    testsRun++;
    if (hs0 - h0 != 4 || hs1 - h1 != 4 || expQ0.size() != 0 || expQ1.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL basic_count: got hs0=%0d hs1=%0d left=%0d, expected 4 4 0",
               hs0 - h0, hs1 - h1, expQ0.size());
    end
    testsRun++;
    if (last0 - l0 != 1) begin testsFailed++; $display("[TB] FAIL basic_last_once: got %0d, expected 1", last0 - l0); end
  endtask

  task automatic test_wrap();
    int h0;
    bit ok;
    h0 = hs0;
    applyStimulus(4095, 2, 3, 1'b1);
    waitDone(50, ok);
    testsRun++;
    if (!ok || hs0 - h0 != 3 || expQ0.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL wrap_count: got ok=%0d hs=%0d left=%0d, expected 1 3 0", ok, hs0 - h0, expQ0.size());
    end
  endtask

  task automatic test_backpressure();
    int h0;
    bit ok;
    h0 = hs0;
    ok = 1'b0;
    applyStimulus(0, 1, 8, 1'b1);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      cReady = (i >= 4 && i < 14) ? 1'b0 : (i % 2 == 0);
      if (!bus0.busy && !bus1.busy) begin
        ok = 1'b1;
        break;
      end
    end
    cReady = 1'b1;
    testsRun++;
    if (!ok || hs0 - h0 != 8 || expQ0.size() != 0 || expQ1.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL bp_count: got ok=%0d hs=%0d left=%0d, expected 1 8 0", ok, hs0 - h0, expQ0.size());
    end
  endtask

  task automatic test_ignored_start();
    int h0;
    bit ok, active;
    h0 = hs0;
    applyStimulus(100, 3, 5, 1'b1);
    applyStimulus(7, 1, 2, 1'b0);
    waitDone(50, ok);
    testsRun++;
    if (!ok || hs0 - h0 != 5 || expQ0.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL ignore_run_start: got ok=%0d hs=%0d left=%0d, expected 1 5 0", ok, hs0 - h0, expQ0.size());
    end
    h0 = hs0;
    active = 1'b0;
    applyStimulus(5, 1, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (bus0.busy || bus0.c_valid || bus1.busy || bus1.c_valid) active = 1'b1;
      @(posedge clk); #1;
    end
    testsRun++;
    if (active || hs0 != h0) begin
      testsFailed++;
      $display("[TB] FAIL ignore_zero_count: got activity=%0d hs=%0d, expected 0 0", active, hs0 - h0);
    end
  endtask

  task automatic test_sweep_reset();
    int h0;
    bit ok;
    h0 = hs0;
    applyStimulus(0, 1, 4096, 1'b1);
    waitDone(5000, ok);
    testsRun++;
    if (!ok || hs0 - h0 != 4096 || expQ0.size() != 0 || expQ1.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL sweep_count: got ok=%0d hs=%0d left=%0d, expected 1 4096 0", ok, hs0 - h0, expQ0.size());
    end
    applyStimulus(0, 1, 4096, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (bus0.c_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.c_last !== 1'b0 ||
        bus1.c_valid !== 1'b0 || bus1.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset: got v=%0d busy=%0d last=%0d, expected 0 0 0",
               bus0.c_valid, bus0.busy, bus0.c_last);
    end
    expQ0.delete();
    expQ1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    h0 = hs0;
    applyStimulus(500, 7, 10, 1'b1);
    waitDone(60, ok);
    testsRun++;
    if (!ok || hs0 - h0 != 10 || expQ0.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL restart: got ok=%0d hs=%0d left=%0d, expected 1 10 0", ok, hs0 - h0, expQ0.size());
    end
  endtask

  task automatic checkOutput();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_ignored_start();
    test_sweep_reset();
    repeat (4) @(posedge clk);
    checkOutput();
    $finish;
  end

endmodule

// File: doc/phasor_gen.md
Name: phasor_gen

Overview:
- Generates the unit-magnitude rotator stream (c_re, c_im) consumed by the complex rotator blocks in the SDFT datapath.
- For each requested angle index a it outputs the phasor exp(±j·2π·a/N) in the same CW-bit signed fixed-point format the rotator expects, where full scale 2**(CW-1)-1 represents 1.0.
- Stores only a quarter-wave cosine table and uses quadrant symmetry; output is a valid/ready stream.

Parameters:
N, 2**12, angle resolution (points per full turn); power of two, >= 16
CW, 16, phasor component width (signed)
INVERSE, 0, 0: c_im = +sin; 1: c_im = -sin (conjugate phasor for de-rotation)
AW (localparam), $clog2(N), angle index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle strobe; launches a sequence, accepted only when busy=0
start_angle  in  AW  first angle index, sampled on accepted start
step  in  AW  angle increment per output, sampled on accepted start
count  in  AW+1  number of phasors to emit (1..N), sampled on accepted start
busy  out  1  high from the cycle after an accepted start until the last phasor's handshake
c_re  out  CW  cos component
c_im  out  CW  sin component (sign per INVERSE)
c_angle  out  AW  angle index of the current output
c_last  out  1  marks the final phasor of the sequence
c_valid  out  1  output valid
c_ready  in  1  downstream ready

Behaviour:
- Reset (async, rst_n=0): busy=0, c_valid=0, c_last=0, c_re=0, c_im=0, c_angle=0. The FSM goes to IDLE and all pipeline valids clear. A reset asserted mid-sequence aborts the sequence; no partial output survives.
- FSM has two states:
  - IDLE: start=1 with count!=0 latches start_angle/step/count and moves to RUN. start with count=0 is ignored.
  - RUN: the issue stage emits one angle per advance cycle. After issuing count angles it stops issuing. FSM returns to IDLE on the handshake (c_valid & c_ready) of the phasor with c_last=1.
  - start in RUN is ignored.
- Angle counter: a_next = (a + step) mod N, i.e. natural AW-bit wrap. step=0 is legal and repeats the same angle.
- Pipeline has 3 stages:
  - S1: quadrant q = a[AW-1:AW-2], r = a[AW-3:0]; register ROM addresses r and N/4-r.
  - S2: registered ROM reads of T[r] and T[N/4-r].
  - S3: sign/swap into c_re/c_im.
  - Latency: first c_valid 3 cycles after the cycle busy rises, given c_ready=1.
- ROM: N/4+1 entries, T[i] = round(cos(2π·i/N)·(2**(CW-1)-1)), i=0..N/4. T[0] = 2**(CW-1)-1, T[N/4] = 0. The ROM is built at elaboration; there is no run-time load.
- Quadrant mapping (s = sine before INVERSE):
  - q0: c_re=T[r], s=T[N/4-r]
  - q1: c_re=-T[N/4-r], s=T[r]
  - q2: c_re=-T[r], s=-T[N/4-r]
  - q3: c_re=T[N/4-r], s=-T[r]
  - c_im = INVERSE ? -s : s.
  - Magnitudes never exceed 2**(CW-1)-1, so negation cannot overflow; -2**(CW-1) is never produced.
- Backpressure: c_valid & !c_ready stalls the entire pipeline and the angle counter (global enable). While stalled, c_re, c_im, c_angle and c_last hold stable. There are no bubbles at throughput 1 when c_ready=1.
- c_last is asserted exactly once per sequence, on output number count. For count=1, the first output is also last.
- Sample timing: start_angle/step/count are sampled only in the accepted-start cycle; changes afterwards have no effect.

Test Plan:
- N=4096, CW=16, INVERSE=0, start_angle=0, step=1024, count=4, c_ready=1 -> outputs (32767,0), (0,32767), (-32767,0), (0,-32767); c_last only on the 4th; first c_valid 3 cycles after busy rises; busy falls after the 4th handshake.
- Same stimulus with INVERSE=1 -> (32767,0), (0,-32767), (-32767,0), (0,32767).
- Wrap: start_angle=4095, step=2, count=3 -> c_angle 4095, 1, 3; c_re=32767 for all three; c_im = -50, +50, +151 (±1 LSB of round(sin(2π·a/4096)·32767)).
- Backpressure: count=8, step=1, c_ready toggled 1/0 every cycle, plus a 10-cycle low window -> c_angle 0..7 in order with none dropped or duplicated, outputs stable during stalls, 8 handshakes total.
- Ignored start: start during RUN with a different start_angle -> original sequence unaffected; start with count=0 in IDLE -> busy stays 0 and no c_valid.
- Sweep and reset: step=1, count=4096, compare every output against a cos/sin model within 1 LSB. Assert rst_n=0 mid-sweep -> c_valid/busy/c_last drop to 0 immediately. A new start after release runs normally from its own start_angle.
